// File: rtl/addsub_pkg.sv
// addsub_pkg
// Shared definitions for the pipelined carry-lookahead add/sub unit:
// default geometry, the stage-record layout and a configuration check
// used at elaboration time by the top level.
package addsub_pkg;

  localparam int DEF_DATA_WIDTH  = 64;
  localparam int DEF_BLOCK_WIDTH = 16;
  localparam int DEF_TAG_WIDTH   = 4;
  localparam int STAGES          = DEF_DATA_WIDTH / DEF_BLOCK_WIDTH;

  // One pipeline stage register at the default geometry. The top level
  // declares the same layout against its own parameters.
  typedef struct packed {
    logic                      valid;
    logic [DEF_DATA_WIDTH-1:0] res;    // result bits resolved so far
    logic                      carry;  // carry out of the last resolved slice
    logic                      c_msb;  // carry into the MSB of that slice
    logic [DEF_DATA_WIDTH-1:0] lhs;    // only slices above the resolved ones matter
    logic [DEF_DATA_WIDTH-1:0] rhs;
    logic                      inv;
    logic [DEF_TAG_WIDTH-1:0]  tag;
  } stage_rec_t;

  function automatic bit cfg_ok(input int data_width, input int block_width);
    return (block_width >= 4) && (data_width >= block_width) &&
           ((data_width % block_width) == 0);
  endfunction

endpackage

// File: rtl/pipelined_cla_addsub_cla_block.sv
// cla_block
// Combinational BLOCK_WIDTH-bit carry-lookahead slice.
//   a, b   : slice operands (b already conditionally inverted)
//   ci     : carry into bit 0 of the slice
//   s      : slice sum
//   co     : carry out of the slice MSB
//   c_msb  : carry into the slice MSB
//   grp_p  : group propagate, grp_g : group generate
module cla_block #(
  parameter int BLOCK_WIDTH = 16
) (
  input  logic [BLOCK_WIDTH-1:0] a,
  input  logic [BLOCK_WIDTH-1:0] b,
  input  logic                   ci,
  output logic [BLOCK_WIDTH-1:0] s,
  output logic                   co,
  output logic                   c_msb,
  output logic                   grp_p,
  output logic                   grp_g
);

  logic [BLOCK_WIDTH-1:0] p;
  logic [BLOCK_WIDTH-1:0] g;
  logic [BLOCK_WIDTH:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is expanded as a flat sum of products of g/p and ci,
  // so no bit waits on the carry of its neighbour.
  always_comb begin
    logic gg;
    logic pp;
    gg = 1'b0;
    pp = 1'b1;
    c  = '0;
    c[0] = ci;
    for (int i = 0; i < BLOCK_WIDTH; i++) begin
      gg = 1'b0;
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        gg = gg | (g[j] & pp);
        pp = pp & p[j];
      end
      c[i+1] = gg | (pp & ci);
    end
  end

  always_comb begin
    grp_g = 1'b0;
    grp_p = 1'b1;
    for (int j = BLOCK_WIDTH - 1; j >= 0; j--) begin
      grp_g = grp_g | (g[j] & grp_p);
      grp_p = grp_p & p[j];
    end
  end

  assign s     = p ^ c[BLOCK_WIDTH-1:0];
  assign co    = c[BLOCK_WIDTH];
  assign c_msb = c[BLOCK_WIDTH-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub
// Integer add/sub execution unit: {cout,res} = lhs + (inv ? ~rhs : rhs) + cin,
// resolved one BLOCK_WIDTH slice per stage with the carry registered between
// stages. Valid/ready on both sides with a single global stall.
//   clk, rst                      : clock, async active-high reset
//   in_valid/in_ready             : operation handshake
//   lhs, rhs, inv, cin, tag       : operation
//   out_valid/out_ready           : result handshake
//   res, cout, of, zero, out_tag  : registered result and flags
module pipelined_cla_addsub
  import addsub_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH,
  parameter int TAG_WIDTH   = DEF_TAG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] lhs,
  input  logic [DATA_WIDTH-1:0] rhs,
  input  logic                  inv,
  input  logic                  cin,
  input  logic [TAG_WIDTH-1:0]  tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] res,
  output logic                  cout,
  output logic                  of,
  output logic                  zero,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int N_STAGES = DATA_WIDTH / BLOCK_WIDTH;

  if (!cfg_ok(DATA_WIDTH, BLOCK_WIDTH)) begin : g_cfg_bad
    $error("pipelined_cla_addsub: DATA_WIDTH must be a multiple of BLOCK_WIDTH >= 4");
  end

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] res;
    logic                  carry;
    logic                  c_msb;
    logic [DATA_WIDTH-1:0] lhs;
    logic [DATA_WIDTH-1:0] rhs;
    logic                  inv;
    logic [TAG_WIDTH-1:0]  tag;
  } stage_t;

  stage_t stg_q [N_STAGES];
  stage_t stg_d [N_STAGES];
  logic   zero_q;
  logic   advance;

  assign advance  = !stg_q[N_STAGES-1].valid || out_ready;
  assign in_ready = advance && !rst;

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    stage_t                 src;
    stage_t                 nxt;
    logic [BLOCK_WIDTH-1:0] s;
    logic                   cm;
    logic                   gp;
    logic                   gg;
    logic                   co_unused;

    if (k == 0) begin : g_head
      always_comb begin
        src       = '0;
        src.valid = in_valid && in_ready;
        src.carry = cin;
        src.lhs   = lhs;
        src.rhs   = rhs;
        src.inv   = inv;
        src.tag   = tag;
      end
    end else begin : g_body
      assign src = stg_q[k-1];
    end

    cla_block #(.BLOCK_WIDTH(BLOCK_WIDTH)) u_cla (
      .a     (src.lhs[k*BLOCK_WIDTH +: BLOCK_WIDTH]),
      .b     (src.rhs[k*BLOCK_WIDTH +: BLOCK_WIDTH] ^ {BLOCK_WIDTH{src.inv}}),
      .ci    (src.carry),
      .s     (s),
      .co    (co_unused),
      .c_msb (cm),
      .grp_p (gp),
      .grp_g (gg)
    );

    // Stage carry taken from the group terms: one AND-OR past the slice.
    always_comb begin
      nxt = src;
      nxt.res[k*BLOCK_WIDTH +: BLOCK_WIDTH] = s;
      nxt.carry = gg | (gp & src.carry);
      nxt.c_msb = cm;
    end

    assign stg_d[k] = nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_STAGES; k++) stg_q[k] <= '0;
      zero_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < N_STAGES; k++) stg_q[k] <= stg_d[k];
      zero_q <= (stg_d[N_STAGES-1].res == '0);
    end
  end

  assign out_valid = stg_q[N_STAGES-1].valid;
  assign res       = stg_q[N_STAGES-1].res;
  assign cout      = stg_q[N_STAGES-1].carry;
  assign of        = stg_q[N_STAGES-1].c_msb ^ stg_q[N_STAGES-1].carry;
  assign zero      = zero_q;
  assign out_tag   = stg_q[N_STAGES-1].tag;

  // Operands are fully consumed by the time a record reaches the output.
  logic ops_unused;
  assign ops_unused = ^{stg_q[N_STAGES-1].lhs, stg_q[N_STAGES-1].rhs,
                        stg_q[N_STAGES-1].inv};

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
module tb_pipelined_cla_addsub;

  localparam int DW  = 64;
  localparam int BW  = 16;
  localparam int TW  = 4;
  localparam int STG = DW / BW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] lhs;
  logic [DW-1:0] rhs;
  logic          inv;
  logic          cin;
  logic [TW-1:0] tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] res;
  logic          cout;
  logic          of;
  logic          zero;
  logic [TW-1:0] out_tag;

  pipelined_cla_addsub #(.DATA_WIDTH(DW), .BLOCK_WIDTH(BW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .lhs(lhs), .rhs(rhs), .inv(inv), .cin(cin), .tag(tag),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .cout(cout),
    .of(of), .zero(zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit rand_rdy = 1'b0;

  typedef struct packed {
    logic [DW-1:0] res;
    logic          cout;
    logic          of;
    logic          zero;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t          exp_q[$];
  logic [TW-1:0] seen_tags[$];

  // Reference: plain wide arithmetic; overflow from operand/result signs.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b_in,
                                 input logic i, input logic c, input logic [TW-1:0] t);
    logic [DW-1:0] b;
    logic [DW:0]   sum;
    exp_t          e;
    b      = i ? ~b_in : b_in;
    sum    = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, c};
    e.res  = sum[DW-1:0];
    e.cout = sum[DW];
    e.of   = (a[DW-1] == b[DW-1]) && (e.res[DW-1] != a[DW-1]);
    e.zero = (e.res == '0);
    e.tag  = t;
    return e;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Scoreboard: every cycle the output is valid it must equal the oldest
  // outstanding operation, popped only when the consumer takes it.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out actual tag=%0h required=no result", out_tag);
        end else begin
          chk("scoreboard", {res, cout, of, zero, out_tag}, exp_q[0]);
          if (out_ready) begin
            seen_tags.push_back(out_tag);
            void'(exp_q.pop_front());
          end
        end
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      else if (!out_valid)         chk("idle_in_ready", in_ready, 1);
      if (in_valid && in_ready) exp_q.push_back(model(lhs, rhs, inv, cin, tag));
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic i, input logic c, input logic [TW-1:0] t);
    int budget = 200;
    bit acc = 1'b0;
    lhs = a; rhs = b; inv = i; cin = c; tag = t; in_valid = 1'b1;
    while (!acc && budget > 0) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      budget--;
    end
    in_valid = 1'b0;
    lhs = {$urandom, $urandom};
    rhs = {$urandom, $urandom};
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=not accepted required=accepted");
    end
  endtask

  task automatic wait_drain();
    int budget = 300;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    end
  endtask

  task automatic lit(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input logic i, input logic c, input logic [DW-1:0] er,
                     input logic ec, input logic eo, input logic ez);
    int   e;
    exp_t m;
    out_ready = 1'b1;
    wait_drain();
    m = model(a, b, i, c, 4'hA);
    chk({name, "_model"}, {m.res, m.cout, m.of, m.zero}, {er, ec, eo, ez});
    send(a, b, i, c, 4'hA);
    e = 1;
    while (!out_valid && e < 20) begin
      @(posedge clk);
      #1;
      e++;
    end
    chk({name, "_latency"}, e, STG);
    chk({name, "_res"}, res, er);
    chk({name, "_flags"}, {cout, of, zero, out_tag}, {ec, eo, ez, 4'hA});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    lhs = '0; rhs = '0; inv = 1'b0; cin = 1'b0; tag = '0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_outputs", {res, cout, of, zero, out_tag}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("release_in_ready", in_ready, 1);

    // Directed literal vectors
    lit("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0,
        64'h8000_0000_0000_0000, 0, 1, 0);
    lit("sub_eq", 64'd5, 64'd5, 1, 1, 64'd0, 1, 0, 1);
    lit("sub_neg", 64'd0, 64'd1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
    lit("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 1, 64'd0, 1, 0, 1);
    lit("sub_minneg", 64'h8000_0000_0000_0000, 64'd1, 1, 1,
        64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0);

    // Backpressure: 8 back-to-back ops, output held for 6 cycles
    out_ready = 1'b1;
    wait_drain();
    seen_tags.delete();
    fork
      begin
        for (int t = 0; t < 8; t++) send(rnd_op(), rnd_op(), t[0], t[0], t[TW-1:0]);
      end
      begin
        int w = 0;
        while (!out_valid && w < 50) begin
          @(posedge clk);
          #1;
          w++;
        end
        out_ready = 1'b0;
        repeat (6) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready, 0);
          chk("bp_out_valid", out_valid, 1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_count", seen_tags.size(), 8);
    for (int i = 0; i < 8 && i < seen_tags.size(); i++) chk("bp_order", seen_tags[i], i);

    // Reset mid-flight with a result sitting at the output
    out_ready = 1'b0;
    send(64'd1, 64'd2, 0, 0, 4'h1);
    send(64'd3, 64'd4, 0, 0, 4'h2);
    send(64'd5, 64'd6, 0, 0, 4'h3);
    @(posedge clk);
    #1;
    chk("prerst_out_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("postrst_in_ready", in_ready, 1);
    repeat (12) @(posedge clk);
    #1;
    chk("postrst_no_stale", out_valid, 0);

    // Random ADD then SUB with random out_ready
    rand_rdy = 1'b1;
    for (int n = 0; n < 1500; n++)
      send(rnd_op(), rnd_op(), 0, 1'($urandom_range(0, 1)), n[TW-1:0]);
    for (int n = 0; n < 1500; n++)
      send(rnd_op(), rnd_op(), 1, 1, n[TW-1:0]);
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();
    chk("final_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
